pipeline_stall_controller: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Merges four inputs into one set of per-stage write-enable, bubble and flush controls:
  - load-use requests from the hazard detection unit,
  - multi-cycle instruction-memory waits,
  - multi-cycle data-memory waits,
  - EX-stage redirects.
- Tracks outstanding memory waits, enforces a data-memory timeout, latches halt, and keeps a stall-cycle performance counter.

---
 rtl/pipeline_stall_controller.sv | 127 ++++++++++++
 tb/tb_pipeline_stall_controller.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline: merges load-use, imem/dmem waits
// and EX redirects into per-stage enables, tracks waits, dmem timeout, halt and stall cycles.
module pipeline_stall_controller #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             loadUse,
  input  logic             imemStall,
  input  logic             imemDone,
  input  logic             dmemStall,
  input  logic             dmemDone,
  input  logic             redirect,
  input  logic             haltWb,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Bubble,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Bubble,
  output logic             imemAbort,
  output logic             halted,
  output logic             memErr,
  output logic [CNT_W-1:0] stallCycles
);

  localparam int DCW = $clog2(MAX_WAIT) + 1;
  localparam logic [DCW-1:0] DCNT_LAST = DCW'(MAX_WAIT - 1);

  logic             d_wait_r;
  logic             i_wait_r;
  logic             halted_r;
  logic             mem_err_r;
  logic [DCW-1:0]   d_cnt_r;
  logic [CNT_W-1:0] stall_cycles_r;

  logic d_freeze_s;
  logic i_hold_s;
  logic timeout_s;

  assign d_freeze_s  = (d_wait_r | dmemStall) & ~dmemDone;
  assign i_hold_s    = (i_wait_r | imemStall) & ~imemDone;
  assign timeout_s   = d_freeze_s & (d_cnt_r == DCNT_LAST);

  assign halted      = halted_r;
  assign memErr      = mem_err_r;
  assign stallCycles = stall_cycles_r;

  // Prioritised per-stage controls; the first matching condition wins.
  always_comb begin
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Write   = 1'b1;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_Write  = 1'b1;
    MEM_WB_Bubble = 1'b0;
    imemAbort     = 1'b0;
    if (halted_r) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
    end else if (d_freeze_s) begin
      // EX is frozen too, so a pending redirect simply stays asserted until release.
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      MEM_WB_Bubble = 1'b1;
    end else if (redirect) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      imemAbort    = i_hold_s;
    end else if (loadUse) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (i_hold_s) begin
      PCWrite     = 1'b0;
      IF_ID_Flush = 1'b1;
    end else begin
      PCWrite = 1'b1;
    end
  end

  // Wait tracking, timeout, sticky halt and saturating stall counter; all frozen once halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_wait_r       <= 1'b0;
      i_wait_r       <= 1'b0;
      halted_r       <= 1'b0;
      mem_err_r      <= 1'b0;
      d_cnt_r        <= {DCW{1'b0}};
      stall_cycles_r <= {CNT_W{1'b0}};
    end else if (!halted_r) begin
      if (timeout_s) begin
        halted_r  <= 1'b1;
        mem_err_r <= 1'b1;
        d_wait_r  <= 1'b0;
        d_cnt_r   <= {DCW{1'b0}};
      end else begin
        if (haltWb) begin
          halted_r <= 1'b1;
        end
        if (dmemDone) begin
          d_wait_r <= 1'b0;
        end else if (dmemStall) begin
          d_wait_r <= 1'b1;
        end
        d_cnt_r <= d_freeze_s ? (d_cnt_r + DCW'(1)) : {DCW{1'b0}};
      end
      // A fetch returning under a data freeze is kept by the frozen IF/ID, so only clear here.
      if (imemDone || imemAbort) begin
        i_wait_r <= 1'b0;
      end else if (imemStall && !d_freeze_s) begin
        i_wait_r <= 1'b1;
      end
      if (!PCWrite && (stall_cycles_r != {CNT_W{1'b1}})) begin
        stall_cycles_r <= stall_cycles_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Table-driven bench for pipeline_stall_controller (MAX_WAIT=4) with an expected-result queue.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic rst, loadUse, imemStall, imemDone, dmemStall, dmemDone, redirect, haltWb;
  logic PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble;
  logic imemAbort, halted, memErr;
  logic [15:0] stallCycles;

  pipeline_stall_controller #(.MAX_WAIT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .loadUse(loadUse), .imemStall(imemStall), .imemDone(imemDone),
    .dmemStall(dmemStall), .dmemDone(dmemDone), .redirect(redirect), .haltWb(haltWb),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Write(ID_EX_Write), .ID_EX_Bubble(ID_EX_Bubble), .EX_MEM_Write(EX_MEM_Write),
    .MEM_WB_Bubble(MEM_WB_Bubble), .imemAbort(imemAbort), .halted(halted), .memErr(memErr),
    .stallCycles(stallCycles)
  );

  always #5 clk = ~clk;

  // input bits {rst, loadUse, imemStall, imemDone, dmemStall, dmemDone, redirect, haltWb}
  localparam logic [7:0] I0 = 8'h00, RS = 8'h80, LU = 8'h40, IS = 8'h20, ID = 8'h10,
                         DS = 8'h08, DD = 8'h04, RD = 8'h02, HW = 8'h01;
  // ctl bits {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble}
  localparam logic [6:0] C_NM = 7'b1101010, C_LU = 7'b0001110, C_DF = 7'b0000001,
                         C_RD = 7'b1111110, C_IH = 7'b0111010, C_HL = 7'b0000000;

  typedef struct packed {
    logic [6:0]  ctl;
    logic        ab;
    logic        h;
    logic        e;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic [7:0] in;
    exp_t       ex;
  } vec_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input logic [7:0] in, input logic [6:0] ctl, input logic ab,
                     input logic h, input logic e, input int cnt);
    vec_t v;
    v.in = in;
    v.ex = '{ctl: ctl, ab: ab, h: h, e: e, cnt: 16'(cnt)};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [7:0] in);
    {rst, loadUse, imemStall, imemDone, dmemStall, dmemDone, redirect, haltWb} = in;
  endtask

  function automatic exp_t actual();
    exp_t a;
    a.ctl = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble};
    a.ab  = imemAbort;
    a.h   = halted;
    a.e   = memErr;
    a.cnt = stallCycles;
    return a;
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got ctl=%b ab=%b h=%b e=%b cnt=%0d, required ctl=%b ab=%b h=%b e=%b cnt=%0d",
                  name, got.ctl, got.ab, got.h, got.e, got.cnt,
                  want.ctl, want.ab, want.h, want.e, want.cnt);
  endtask

  initial begin
    exp_t want;
    int   n;
    logic done;

    // reset / loadUse
    add(I0,      C_NM, 0, 0, 0, 0);
    add(LU,      C_LU, 0, 0, 0, 0);
    add(I0,      C_NM, 0, 0, 0, 1);
    // dmem freeze with redirect held; release on dmemDone applies redirect
    add(DS|RD,   C_DF, 0, 0, 0, 1);
    add(RD,      C_DF, 0, 0, 0, 2);
    add(RD,      C_DF, 0, 0, 0, 3);
    add(RD|DD,   C_RD, 0, 0, 0, 4);
    add(I0,      C_NM, 0, 0, 0, 4);
    // imem hold then redirect aborts the fetch
    add(IS,      C_IH, 0, 0, 0, 4);
    add(I0,      C_IH, 0, 0, 0, 5);
    add(RD,      C_RD, 1, 0, 0, 6);
    add(I0,      C_NM, 0, 0, 0, 6);
    // loadUse beats imemStall; imemDone next cycle releases
    add(LU|IS,   C_LU, 0, 0, 0, 6);
    add(ID,      C_NM, 0, 0, 0, 7);
    add(I0,      C_NM, 0, 0, 0, 7);
    // stall and done together: no freeze
    add(DS|DD,   C_NM, 0, 0, 0, 7);
    // imemDone during data freeze clears the fetch wait
    add(IS,      C_IH, 0, 0, 0, 7);
    add(DS,      C_DF, 0, 0, 0, 8);
    add(ID,      C_DF, 0, 0, 0, 9);
    add(DD,      C_NM, 0, 0, 0, 10);
    add(I0,      C_NM, 0, 0, 0, 10);
    // reset in the middle of both waits
    add(DS|IS,   C_DF, 0, 0, 0, 10);
    add(RS,      C_NM, 0, 0, 0, 0);
    add(I0,      C_NM, 0, 0, 0, 0);
    // data-memory timeout after 4 freeze cycles
    add(DS,      C_DF, 0, 0, 0, 0);
    add(I0,      C_DF, 0, 0, 0, 1);
    add(I0,      C_DF, 0, 0, 0, 2);
    add(I0,      C_DF, 0, 0, 0, 3);
    add(I0,      C_HL, 0, 1, 1, 4);
    add(LU|RD,   C_HL, 0, 1, 1, 4);
    add(RS,      C_NM, 0, 0, 0, 0);
    add(I0,      C_NM, 0, 0, 0, 0);
    // haltWb: that cycle normal, halted afterwards, later requests ignored
    add(HW,      C_NM, 0, 0, 0, 0);
    add(LU|DS,   C_HL, 0, 1, 0, 0);
    add(IS,      C_HL, 0, 1, 0, 0);
    add(RS,      C_NM, 0, 0, 0, 0);
    // redirect beats loadUse; same-cycle imemStall is aborted
    add(LU|RD|IS, C_RD, 1, 0, 0, 0);
    add(I0,      C_NM, 0, 0, 0, 0);

    drive(RS);
    repeat (2) @(posedge clk);
    #1;
    drive(I0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i].in);
      exp_q.push_back(vecs[i].ex);
      @(negedge clk);
      want = exp_q.pop_front();
      check($sformatf("row%0d", i), actual(), want);
    end

    // Hand sequence: hold dmemStall and wait (bounded) for the timeout halt
    @(posedge clk);
    #1;
    drive(DS);
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      if (halted) done = 1'b1;
      else begin
        n++;
        @(posedge clk);
        #1;
      end
    end
    n_checks++;
    if (done && n == 4) n_pass++;
    else $display("FAIL timeout_len: got %0d freeze cycles (halted=%b), required 4", n, done);
    check("timeout_state", actual(), '{ctl: C_HL, ab: 1'b0, h: 1'b1, e: 1'b1, cnt: 16'd4});

    // Reset while halted clears everything
    @(posedge clk);
    #1;
    drive(RS);
    @(negedge clk);
    check("reset_after_err", actual(), '{ctl: C_NM, ab: 1'b0, h: 1'b0, e: 1'b0, cnt: 16'd0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
